// File: rtl/sysx_pkg.sv
// Shared sysX definitions: frame states, bus widths, select and fill constants.
package sysx_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_LANES = WORD_W / BYTE_W;
  localparam int unsigned SEL_W     = 2;

  localparam logic [SEL_W-1:0]  SELECT_IDLE = 2'h0;
  localparam logic [WORD_W-1:0] FILL_WORD   = 32'h0BADC0DE;
  localparam logic [BYTE_W-1:0] IDLE_BYTE   = 8'h00;

  // Byte lanes of a bus word, lane 0 = bits 7:0 (first on the wire).
  typedef logic [NUM_LANES-1:0][BYTE_W-1:0] wordLanes_t;

  // Frame sequence, also used by the master's pipeline.
  typedef enum logic [2:0] {
    FRAME_IDLE,
    FRAME_LOAD,
    FRAME_B0,
    FRAME_B1,
    FRAME_B2,
    FRAME_B3,
    FRAME_STORE
  } frameState_t;

  // True for the four byte-shifting states.
  function automatic logic isByteState(input frameState_t s);
    return (s == FRAME_B0) || (s == FRAME_B1) || (s == FRAME_B2) || (s == FRAME_B3);
  endfunction

  // Byte lane handled in a byte-shifting state.
  function automatic logic [1:0] laneOf(input frameState_t s);
    case (s)
      FRAME_B1: laneOf = 2'd1;
      FRAME_B2: laneOf = 2'd2;
      FRAME_B3: laneOf = 2'd3;
      default:  laneOf = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sysx_sync.sv
// Multi-bit, multi-stage synchronizer; all bits share the same delay.
module sysx_sync #(
  parameter int unsigned pWidth = 1,
  parameter int unsigned pDepth = 2
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [pWidth-1:0] iData,
  output logic [pWidth-1:0] oData
);

  logic [pDepth-1:0][pWidth-1:0] stages;

  // Shift the bundle through the flop chain.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      stages <= '0;
    end else begin
      stages <= {stages[pDepth-2:0], iData};
    end
  end

  assign oData = stages[pDepth-1];

endmodule

// File: rtl/sysx_slave.sv
// sysX bus responder: oversampled bus clock, one 32-bit word per frame, byte per edge.
module sysx_slave
  import sysx_pkg::*;
#(
  parameter logic [SEL_W-1:0]  pSelectCode = 2'h1,
  parameter int unsigned       pSyncStages = 2,
  parameter logic [WORD_W-1:0] pFillWord   = FILL_WORD
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iBusClock,
  input  logic [SEL_W-1:0]  iBusSelect,
  input  logic [BYTE_W-1:0] iBusMOSI,
  output logic [BYTE_W-1:0] oBusMISO,
  output logic              oBusInterrupt,
  output logic [WORD_W-1:0] oRxData,
  output logic              oRxValid,
  input  logic [WORD_W-1:0] iTxData,
  input  logic              iTxValid,
  output logic              oTxReady,
  output logic              oTxUnderrun,
  input  logic              iIrqRequest
);

  localparam int unsigned BUNDLE_W = 1 + SEL_W + BYTE_W;

  logic [BUNDLE_W-1:0] syncBundle;
  logic                syncClock;
  logic [SEL_W-1:0]    syncSelect;
  logic [BYTE_W-1:0]   syncMosi;
  logic                busClockPrev;
  logic                busRise;
  logic                busFall;
  logic                selected;
  logic                txAccept;
  frameState_t         state;
  frameState_t         stateNext;
  wordLanes_t          txShift;
  wordLanes_t          txHold;
  wordLanes_t          rxShift;

  sysx_sync #(
    .pWidth(BUNDLE_W),
    .pDepth(pSyncStages)
  ) uSync (
    .iClock(iClock),
    .iReset(iReset),
    .iData ({iBusClock, iBusSelect, iBusMOSI}),
    .oData (syncBundle)
  );

  assign {syncClock, syncSelect, syncMosi} = syncBundle;
  assign busRise  = syncClock & ~busClockPrev;
  assign busFall  = ~syncClock & busClockPrev;
  assign selected = (syncSelect == pSelectCode) && (pSelectCode != SELECT_IDLE);
  assign txAccept = iTxValid & oTxReady;

  // Previous synced bus clock for edge detection.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) busClockPrev <= 1'b0;
    else        busClockPrev <= syncClock;
  end

  // Frame state register.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= FRAME_IDLE;
    else        state <= stateNext;
  end

  // Next frame state: deselect wins at any cycle, otherwise step on each rise.
  always_comb begin
    stateNext = state;
    if (!selected) begin
      stateNext = FRAME_IDLE;
    end else if (busRise) begin
      case (state)
        FRAME_IDLE:  stateNext = FRAME_LOAD;
        FRAME_LOAD:  stateNext = FRAME_B0;
        FRAME_B0:    stateNext = FRAME_B1;
        FRAME_B1:    stateNext = FRAME_B2;
        FRAME_B2:    stateNext = FRAME_B3;
        FRAME_B3:    stateNext = FRAME_STORE;
        FRAME_STORE: stateNext = FRAME_LOAD;
        default:     stateNext = FRAME_IDLE;
      endcase
    end
  end

  // Holding register handshake and LOAD transfer into the tx shifter.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      txHold      <= '0;
      txShift     <= '0;
      oTxReady    <= 1'b1;
      oTxUnderrun <= 1'b0;
    end else begin
      oTxUnderrun <= 1'b0;
      if (txAccept) begin
        txHold   <= iTxData;
        oTxReady <= 1'b0;
      end
      if (selected && busRise && state == FRAME_LOAD) begin
        if (!oTxReady) begin
          txShift  <= txHold;
          oTxReady <= 1'b1;
        end else begin
          txShift     <= pFillWord;
          oTxUnderrun <= 1'b1;
        end
      end
    end
  end

  // Byte capture on rises in B0..B3 and word publish on the STORE rise.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rxShift  <= '0;
      oRxData  <= '0;
      oRxValid <= 1'b0;
    end else begin
      oRxValid <= 1'b0;
      if (selected && busRise) begin
        if (isByteState(state)) begin
          rxShift[laneOf(state)] <= syncMosi;
        end else if (state == FRAME_STORE) begin
          oRxData  <= rxShift;
          oRxValid <= 1'b1;
        end
      end
    end
  end

  // MISO changes only on falls; forced idle whenever not selected.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oBusMISO <= IDLE_BYTE;
    end else if (!selected) begin
      oBusMISO <= IDLE_BYTE;
    end else if (busFall) begin
      oBusMISO <= isByteState(state) ? txShift[laneOf(state)] : IDLE_BYTE;
    end
  end

  // Interrupt: local request, or a queued word waiting while the bus is idle.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) oBusInterrupt <= 1'b0;
    else        oBusInterrupt <= iIrqRequest | (~oTxReady & (state == FRAME_IDLE));
  end

endmodule

// File: tb/tb_sysx_slave.sv
// Self-checking bench for sysx_slave: bus master model plus rx scoreboard.
module tb_sysx_slave;

  localparam int unsigned HALF      = 6;
  localparam logic [31:0] FILL      = 32'h0BADC0DE;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iBusClock;
  logic [1:0]  iBusSelect;
  logic [7:0]  iBusMOSI;
  logic [7:0]  oBusMISO;
  logic        oBusInterrupt;
  logic [31:0] oRxData;
  logic        oRxValid;
  logic [31:0] iTxData;
  logic        iTxValid;
  logic        oTxReady;
  logic        oTxUnderrun;
  logic        iIrqRequest;

  int testsRun    = 0;
  int testsFailed = 0;
  int rxPulses    = 0;
  int underruns   = 0;

  logic [31:0] expRx[$];
  logic        holdFull = 1'b0;
  logic [31:0] holdWord = '0;

  sysx_slave dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .iBusClock    (iBusClock),
    .iBusSelect   (iBusSelect),
    .iBusMOSI     (iBusMOSI),
    .oBusMISO     (oBusMISO),
    .oBusInterrupt(oBusInterrupt),
    .oRxData      (oRxData),
    .oRxValid     (oRxValid),
    .iTxData      (iTxData),
    .iTxValid     (iTxValid),
    .oTxReady     (oTxReady),
    .oTxUnderrun  (oTxUnderrun),
    .iIrqRequest  (iIrqRequest)
  );

  always #5 iClock = ~iClock;

  // One local cycle; pops the rx scoreboard on every oRxValid pulse.
  task automatic tick();
    logic [31:0] expWord;
    @(negedge iClock);
    if (oRxValid === 1'b1) begin
      rxPulses++;
      testsRun++;
      if (expRx.size() == 0) begin
        testsFailed++;
        $display("FAIL rx_unexpected: oRxValid with oRxData=%h, required no pulse", oRxData);
      end else begin
        expWord = expRx.pop_front();
        if (oRxData !== expWord) begin
          testsFailed++;
          $display("FAIL rx_word: oRxData=%h, required %h", oRxData, expWord);
        end
      end
    end
    if (oTxUnderrun === 1'b1) underruns++;
  endtask

  // Master bus cycle: fall + drive MOSI, sample MISO just before the rise.
  task automatic busCycle(input logic [7:0] mosi, input logic [7:0] expMiso);
    iBusClock = 1'b0;
    iBusMOSI  = mosi;
    repeat (HALF) tick();
    testsRun++;
    if (oBusMISO !== expMiso) begin
      testsFailed++;
      $display("FAIL miso_byte: oBusMISO=%h, required %h", oBusMISO, expMiso);
    end
    iBusClock = 1'b1;
    repeat (HALF) tick();
  endtask

  // Offer a word on the tx handshake for one cycle.
  task automatic offerWord(input logic [31:0] w);
    iTxData  = w;
    iTxValid = 1'b1;
    tick();
    iTxValid = 1'b0;
    holdFull = 1'b1;
    holdWord = w;
    testsRun++;
    if (oTxReady !== 1'b0) begin
      testsFailed++;
      $display("FAIL tx_accept: oTxReady=%b, required 0", oTxReady);
    end
  endtask

  // Full frame with the device already selected.
  task automatic runFrame(input logic fromIdle, input logic [31:0] mosiWord,
                          input logic queueNext, input logic [31:0] nextWord,
                          input logic irqMid);
    logic [31:0] misoWord;
    logic        expFill;
    int          u0;
    misoWord = holdFull ? holdWord : FILL;
    expFill  = !holdFull;
    holdFull = 1'b0;
    expRx.push_back(mosiWord);
    if (fromIdle) busCycle(8'h00, 8'h00);
    u0 = underruns;
    busCycle(8'h00, 8'h00);
    testsRun++;
    if ((underruns - u0) != (expFill ? 1 : 0)) begin
      testsFailed++;
      $display("FAIL underrun_count: pulses=%0d, required %0d", underruns - u0, expFill ? 1 : 0);
    end
    testsRun++;
    if (oTxReady !== 1'b1) begin
      testsFailed++;
      $display("FAIL ready_after_load: oTxReady=%b, required 1", oTxReady);
    end
    testsRun++;
    if (oBusInterrupt !== iIrqRequest) begin
      testsFailed++;
      $display("FAIL irq_after_load: oBusInterrupt=%b, required %b", oBusInterrupt, iIrqRequest);
    end
    if (queueNext) offerWord(nextWord);
    for (int i = 0; i < 4; i++) begin
      if (irqMid && i == 2) iIrqRequest = 1'b1;
      busCycle(mosiWord[8*i +: 8], misoWord[8*i +: 8]);
    end
    if (irqMid) begin
      testsRun++;
      if (oBusInterrupt !== 1'b1) begin
        testsFailed++;
        $display("FAIL irq_mid_frame: oBusInterrupt=%b, required 1", oBusInterrupt);
      end
    end
    busCycle(8'h00, 8'h00);
  endtask

  task automatic checkResetValues(input string tag);
    testsRun++;
    if (oBusMISO !== 8'h00 || oBusInterrupt !== 1'b0 || oRxData !== 32'h0 ||
        oRxValid !== 1'b0 || oTxReady !== 1'b1 || oTxUnderrun !== 1'b0) begin
      testsFailed++;
      $display("FAIL %s: miso=%h irq=%b rx=%h rxv=%b rdy=%b und=%b, required 00 0 00000000 0 1 0",
               tag, oBusMISO, oBusInterrupt, oRxData, oRxValid, oTxReady, oTxUnderrun);
    end
  endtask

  task automatic deselect();
    iBusSelect = 2'h0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    iReset = 1'b1; iBusClock = 1'b0; iBusSelect = 2'h0; iBusMOSI = 8'h00;
    iTxData = '0; iTxValid = 1'b0; iIrqRequest = 1'b0;
    repeat (3) tick();
    checkResetValues("reset_held");
    iReset = 1'b0;
    repeat (3) tick();
    checkResetValues("reset_released");
  endtask

  task automatic test_basic();
    offerWord(32'hA1B2C3D4);
    iBusSelect = 2'h1;
    runFrame(1'b1, 32'h44332211, 1'b0, '0, 1'b0);
    deselect();
  endtask

  task automatic test_underrun();
    iBusSelect = 2'h1;
    runFrame(1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    deselect();
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = rxPulses;
    offerWord(32'h0000_0001);
    iBusSelect = 2'h1;
    runFrame(1'b1, 32'h8899AABB, 1'b1, 32'h0000_0002, 1'b0);
    runFrame(1'b0, 32'h01020304, 1'b0, '0, 1'b0);
    deselect();
    testsRun++;
    if (rxPulses - p0 != 2) begin
      testsFailed++;
      $display("FAIL b2b_pulses: rx pulses=%0d, required 2", rxPulses - p0);
    end
  endtask

  task automatic test_deselect();
    iBusSelect = 2'h1;
    busCycle(8'h00, 8'h00);
    busCycle(8'h00, 8'h00);
    holdFull = 1'b0;
    busCycle(8'h5A, 8'hDE);
    busCycle(8'hA5, 8'hC0);
    iBusSelect = 2'h0;
    repeat (2) tick();
    testsRun++;
    if (oBusMISO !== 8'hC0) begin
      testsFailed++;
      $display("FAIL deselect_early: oBusMISO=%h, required c0", oBusMISO);
    end
    tick();
    testsRun++;
    if (oBusMISO !== 8'h00) begin
      testsFailed++;
      $display("FAIL deselect_miso: oBusMISO=%h, required 00", oBusMISO);
    end
    repeat (8) tick();
    iBusSelect = 2'h1;
    runFrame(1'b1, 32'hCAFEF00D, 1'b0, '0, 1'b0);
    deselect();
  endtask

  task automatic test_other_select();
    int u0;
    int p0;
    u0 = underruns;
    p0 = rxPulses;
    iBusSelect = 2'h2;
    for (int i = 0; i < 8; i++) busCycle(8'($urandom_range(255)), 8'h00);
    deselect();
    testsRun++;
    if (underruns != u0 || rxPulses != p0) begin
      testsFailed++;
      $display("FAIL other_select: underruns=%0d rx=%0d, required 0 0", underruns - u0, rxPulses - p0);
    end
  endtask

  task automatic test_irq();
    iIrqRequest = 1'b0;
    repeat (3) tick();
    testsRun++;
    if (oBusInterrupt !== 1'b0) begin
      testsFailed++;
      $display("FAIL irq_quiet: oBusInterrupt=%b, required 0", oBusInterrupt);
    end
    offerWord(32'h13572468);
    repeat (3) tick();
    testsRun++;
    if (oBusInterrupt !== 1'b1) begin
      testsFailed++;
      $display("FAIL irq_queued_idle: oBusInterrupt=%b, required 1", oBusInterrupt);
    end
    iBusSelect = 2'h1;
    runFrame(1'b1, 32'h0F1E2D3C, 1'b0, '0, 1'b1);
    iIrqRequest = 1'b0;
    deselect();
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    iBusSelect = 2'h1;
    busCycle(8'h00, 8'h00);
    busCycle(8'h00, 8'h00);
    offerWord(32'h55667788);
    busCycle(8'hAA, 8'hDE);
    busCycle(8'hBB, 8'hC0);
    iBusClock = 1'b0;
    iBusMOSI  = 8'hCC;
    repeat (4) tick();
    p0 = rxPulses;
    #2 iReset = 1'b1;
    #1 checkResetValues("reset_mid_frame");
    iBusSelect = 2'h0;
    holdFull = 1'b0;
    repeat (2) tick();
    iReset = 1'b0;
    repeat (10) tick();
    testsRun++;
    if (rxPulses != p0) begin
      testsFailed++;
      $display("FAIL reset_no_rx: rx pulses=%0d, required 0", rxPulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_deselect();
    test_other_select();
    test_irq();
    test_reset_mid_frame();
    testsRun++;
    if (expRx.size() != 0) begin
      testsFailed++;
      $display("FAIL rx_missing: %0d words never received, required 0", expRx.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
